branch_stall_ctrl: RTL and testbench

BRANCH_STALL_CTRL -- requirements
Module: branch_stall_ctrl

---
 rtl/branch_stall_ctrl.sv | 161 ++++++++++++++++
 tb/tb_branch_stall_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/branch_stall_ctrl.sv
// Branch resolution stall controller for the D stage.
// Works out how many cycles a conditional branch must wait for its source
// operands to become forwardable, freezes F/D for that long, then strobes
// the branch decision and keeps saturating statistics on resolved/taken branches.
module branch_stall_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_is_branch,
  input  logic [2:0]        d_br_type,
  input  logic [4:0]        d_rs,
  input  logic [4:0]        d_rt,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              e_wr_en,
  input  logic [4:0]        e_wr_reg,
  input  logic              e_is_load,
  input  logic              m_wr_en,
  input  logic [4:0]        m_wr_reg,
  input  logic              m_is_load,
  output logic              stall,
  output logic              br_valid,
  output logic              br_taken,
  output logic [15:0]       br_cnt,
  output logic [15:0]       taken_cnt
);

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLEZ = 3'b010;
  localparam logic [2:0] BR_BGTZ = 3'b011;
  localparam logic [2:0] BR_BLTZ = 3'b100;
  localparam logic [2:0] BR_BGEZ = 3'b101;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] br_cnt_q, br_cnt_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;

  logic        use_rs, use_rt;
  logic [1:0]  need_rs, need_rt, need_n;
  logic        cond;
  logic        stall_c, valid_c;

  logic signed [DATA_W-1:0] rs_s;
  logic signed [DATA_W-1:0] rt_s;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Cycles one source register must wait. An E-stage writer dominates an
  // M-stage one (it is younger and always needs at least as long), and an
  // M-stage ALU result is already forwardable so it costs nothing.
  function automatic logic [1:0] reg_need(input logic [4:0] r,
                                          input logic       ew,
                                          input logic [4:0] er,
                                          input logic       el,
                                          input logic       mw,
                                          input logic [4:0] mr,
                                          input logic       ml);
    logic [1:0] n;
    n = 2'd0;
    if (r != 5'd0) begin
      if (mw && (mr == r) && ml) n = 2'd1;
      if (ew && (er == r))       n = el ? 2'd2 : 2'd1;
    end
    return n;
  endfunction

  assign rs_s = signed'(rs_val);
  assign rt_s = signed'(rt_val);

  // Operand usage, hazard depth and branch condition from the current D-stage inputs.
  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    cond   = 1'b0;
    case (d_br_type)
      BR_BEQ:  begin use_rs = 1'b1; use_rt = 1'b1; cond = (rs_s == rt_s);          end
      BR_BNE:  begin use_rs = 1'b1; use_rt = 1'b1; cond = (rs_s != rt_s);          end
      BR_BLEZ: begin use_rs = 1'b1; cond = (rs_s < 0) || (rs_s == 0);              end
      BR_BGTZ: begin use_rs = 1'b1; cond = !((rs_s < 0) || (rs_s == 0));           end
      BR_BLTZ: begin use_rs = 1'b1; cond = (rs_s < 0);                             end
      BR_BGEZ: begin use_rs = 1'b1; cond = !(rs_s < 0);                            end
      default: begin use_rs = 1'b0; use_rt = 1'b0; cond = 1'b0;                    end
    endcase

    need_rs = use_rs ? reg_need(d_rs, e_wr_en, e_wr_reg, e_is_load,
                                m_wr_en, m_wr_reg, m_is_load) : 2'd0;
    need_rt = use_rt ? reg_need(d_rt, e_wr_en, e_wr_reg, e_is_load,
                                m_wr_en, m_wr_reg, m_is_load) : 2'd0;
    need_n  = (need_rs > need_rt) ? need_rs : need_rt;
  end

  // Stall FSM: hazard depth is sampled once on entry, WAIT just counts down.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    valid_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (d_is_branch) begin
          if (need_n == 2'd0) begin
            valid_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            cnt_d   = need_n - 2'd1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 2'd0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 2'd1;
        end else begin
          valid_c = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Outputs are forced quiet for as long as reset is held.
  always_comb begin
    stall    = stall_c & ~reset;
    br_valid = valid_c & ~reset;
    br_taken = valid_c & cond & ~reset;
    br_cnt_d    = br_valid ? sat_inc(br_cnt_q) : br_cnt_q;
    taken_cnt_d = br_taken ? sat_inc(taken_cnt_q) : taken_cnt_q;
  end

  // State, countdown and statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      br_cnt_q    <= 16'd0;
      taken_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign br_cnt    = br_cnt_q;
  assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_stall_ctrl.sv
// Scoreboard bench for branch_stall_ctrl: directed branches push their
// expected decision, a negedge monitor pops one entry per br_valid strobe.
module tb_branch_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_is_branch;
  logic [2:0]  d_br_type;
  logic [4:0]  d_rs, d_rt;
  logic [31:0] rs_val, rt_val;
  logic        e_wr_en, e_is_load, m_wr_en, m_is_load;
  logic [4:0]  e_wr_reg, m_wr_reg;
  logic        stall, br_valid, br_taken;
  logic [15:0] br_cnt, taken_cnt;

  typedef struct {
    logic        taken;
    int          stalls;
    logic [15:0] bc;
    logic [15:0] tc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          stall_run = 0;
  logic [15:0] exp_bc = 16'd0;
  logic [15:0] exp_tc = 16'd0;

  branch_stall_ctrl dut (
    .clk(clk), .reset(reset),
    .d_is_branch(d_is_branch), .d_br_type(d_br_type),
    .d_rs(d_rs), .d_rt(d_rt), .rs_val(rs_val), .rt_val(rt_val),
    .e_wr_en(e_wr_en), .e_wr_reg(e_wr_reg), .e_is_load(e_is_load),
    .m_wr_en(m_wr_en), .m_wr_reg(m_wr_reg), .m_is_load(m_is_load),
    .stall(stall), .br_valid(br_valid), .br_taken(br_taken),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_writers();
    e_wr_en = 1'b0; e_wr_reg = 5'd0; e_is_load = 1'b0;
    m_wr_en = 1'b0; m_wr_reg = 5'd0; m_is_load = 1'b0;
  endtask

  task automatic idle(input int cycles);
    d_is_branch = 1'b0;
    clear_writers();
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  // Presents one branch for exp_st+1 cycles; hazard writers are only shown in
  // the first cycle and rs_val only takes its decision value in the last one.
  task automatic issue(input logic [2:0] ty, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsv_stall, input logic [31:0] rsv,
                       input logic [31:0] rtv,
                       input logic ew, input logic [4:0] er, input logic el,
                       input logic mw, input logic [4:0] mr, input logic ml,
                       input logic exp_tk, input int exp_st);
    exp_t e;
    e.taken = exp_tk; e.stalls = exp_st; e.bc = exp_bc; e.tc = exp_tc;
    sb_q.push_back(e);
    if (exp_bc != 16'hFFFF) exp_bc = exp_bc + 16'd1;
    if (exp_tk && exp_tc != 16'hFFFF) exp_tc = exp_tc + 16'd1;
    d_is_branch = 1'b1; d_br_type = ty; d_rs = rs; d_rt = rt; rt_val = rtv;
    e_wr_en = ew; e_wr_reg = er; e_is_load = el;
    m_wr_en = mw; m_wr_reg = mr; m_is_load = ml;
    for (int c = 0; c <= exp_st; c++) begin
      rs_val = (c == exp_st) ? rsv : rsv_stall;
      if (c > 0) clear_writers();
      @(posedge clk); #1;
    end
  endtask

  // Monitor: one scoreboard entry per decision strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_run = 0;
      end else if (br_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("taken", {31'd0, br_taken}, {31'd0, e.taken});
          chk("stall_cycles", stall_run, e.stalls);
          chk("stall_with_valid", {31'd0, stall}, 32'd0);
          chk("br_cnt_pre", {16'd0, br_cnt}, {16'd0, e.bc});
          chk("taken_cnt_pre", {16'd0, taken_cnt}, {16'd0, e.tc});
        end
        stall_run = 0;
      end else begin
        if (br_taken !== 1'b0) chk("taken_without_valid", {31'd0, br_taken}, 32'd0);
        if (stall) stall_run++;
      end
    end
  end

  initial begin
    // Reset with a hazard-free branch on the inputs: outputs must stay quiet.
    reset = 1'b1;
    clear_writers();
    d_is_branch = 1'b1; d_br_type = 3'b000; d_rs = 5'd3; d_rt = 5'd4;
    rs_val = 32'd5; rt_val = 32'd5;
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_valid", {31'd0, br_valid}, 32'd0);
    chk("rst_taken", {31'd0, br_taken}, 32'd0);
    chk("rst_br_cnt", {16'd0, br_cnt}, 32'd0);
    chk("rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    //     type    rs     rt     rs@stall      rs@decide     rt_val        ew    er     el    mw    mr     ml    tk    n
    issue(3'b000, 5'd3,  5'd4,  32'd5,        32'd5,        32'd5,        1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 0); idle(1);
    issue(3'b010, 5'd8,  5'd0,  32'd7,        32'd0,        32'd0,        1'b1, 5'd8,  1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 2); idle(1);
    issue(3'b001, 5'd2,  5'd6,  32'd1,        32'd1,        32'd2,        1'b1, 5'd6,  1'b0, 1'b1, 5'd2,  1'b1, 1'b1, 1); idle(1);
    issue(3'b101, 5'd0,  5'd0,  32'd0,        32'd0,        32'd0,        1'b1, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 0); idle(1);
    issue(3'b011, 5'd1,  5'd9,  32'd5,        32'd5,        32'd0,        1'b1, 5'd9,  1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 0); idle(1);
    issue(3'b100, 5'd4,  5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b0, 5'd0,  1'b0, 1'b1, 5'd4,  1'b0, 1'b1, 0); idle(1);
    issue(3'b011, 5'd5,  5'd0,  32'd9,        32'd0,        32'd0,        1'b1, 5'd5,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1); idle(1);
    issue(3'b000, 5'd11, 5'd10, 32'd3,        32'd3,        32'd4,        1'b1, 5'd10, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 2); idle(1);
    issue(3'b001, 5'd12, 5'd13, 32'd9,        32'd9,        32'd9,        1'b0, 5'd0,  1'b0, 1'b1, 5'd13, 1'b1, 1'b0, 1); idle(1);
    issue(3'b110, 5'd1,  5'd2,  32'd0,        32'd0,        32'd0,        1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 0); idle(1);
    issue(3'b101, 5'd3,  5'd0,  32'h80000000, 32'h80000000, 32'd0,        1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 0); idle(1);
    issue(3'b010, 5'd14, 5'd0,  32'd1,        32'd1,        32'd0,        1'b0, 5'd0,  1'b0, 1'b1, 5'd14, 1'b1, 1'b0, 1); idle(1);
    issue(3'b100, 5'd15, 5'd0,  32'd0,        32'd0,        32'd0,        1'b1, 5'd15, 1'b0, 1'b1, 5'd15, 1'b1, 1'b0, 1); idle(1);
    issue(3'b000, 5'd16, 5'd17, 32'd7,        32'd7,        32'd7,        1'b1, 5'd16, 1'b1, 1'b1, 5'd17, 1'b1, 1'b1, 2); idle(2);

    // 14 decisions, 7 of them taken.
    chk("dir_br_cnt", {16'd0, br_cnt}, 32'd14);
    chk("dir_taken_cnt", {16'd0, taken_cnt}, 32'd7);
    chk("dir_idle_stall", {31'd0, stall}, 32'd0);

    // Reset in the middle of a two-cycle load-use wait: no decision may appear.
    d_is_branch = 1'b1; d_br_type = 3'b010; d_rs = 5'd8; d_rt = 5'd0;
    rs_val = 32'd0; rt_val = 32'd0;
    e_wr_en = 1'b1; e_wr_reg = 5'd8; e_is_load = 1'b1;
    @(posedge clk); #1;
    clear_writers();
    @(negedge clk);
    chk("abort_pre_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    d_br_type = 3'b000; d_rs = 5'd3; d_rt = 5'd4; rs_val = 32'd5; rt_val = 32'd5;
    @(negedge clk);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_valid", {31'd0, br_valid}, 32'd0);
    chk("abort_br_cnt", {16'd0, br_cnt}, 32'd0);
    chk("abort_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    exp_bc = 16'd0; exp_tc = 16'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(4);

    // 70000 back-to-back taken branches drive both counters into saturation.
    for (int k = 0; k < 70000; k++)
      issue(3'b000, 5'd3, 5'd4, 32'd5, 32'd5, 32'd5,
            1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 0);
    idle(3);
    chk("sat_br_cnt", {16'd0, br_cnt}, 32'h0000FFFF);
    chk("sat_taken_cnt", {16'd0, taken_cnt}, 32'h0000FFFF);
    chk("pending_decisions", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
